// File: rtl/lcd_msg_sequencer.sv
// lcd_msg_sequencer: plays a fixed-length message onto an LCD controller
// (clear, then one register write per byte) while echoing every byte to a
// UART transmitter. A 0x00 byte or the end of the buffer ends the message;
// 0x0A is turned into a "cursor to line 2" command.
`timescale 1ns/1ps

module lcd_msg_sequencer #(
  parameter int CLK_FREQ    = 25000000,
  parameter int MSG_LEN     = 16,
  parameter int INIT_DELAY  = 375000,
  parameter int CMD_DELAY   = 50000,
  parameter int CHAR_DELAY  = 25000,
  parameter int HOLD_CYCLES = 10,
  parameter int AUTO_START  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*MSG_LEN-1:0] msg,
  output logic                 lcd_cs,
  output logic                 lcd_we,
  output logic [7:0]           lcd_addr,
  output logic [7:0]           lcd_wdata,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  input  logic                 uart_busy,
  output logic                 busy,
  output logic                 done,
  output logic [5:0]           char_idx
);

  localparam int MAX_A     = (INIT_DELAY > CMD_DELAY) ? INIT_DELAY : CMD_DELAY;
  localparam int MAX_B     = (CHAR_DELAY > HOLD_CYCLES) ? CHAR_DELAY : HOLD_CYCLES;
  localparam int MAX_DELAY = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW        = $clog2(MAX_DELAY) + 1;

  localparam logic [5:0] END_IDX = 6'(MSG_LEN);
  localparam logic [7:0] REG_DATA = 8'h00;
  localparam logic [7:0] REG_CMD  = 8'h01;
  localparam logic [7:0] CMD_CLR  = 8'h01;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  // Reject illegal configurations at elaboration time.
  if (CLK_FREQ < 1 || MSG_LEN < 1 || MSG_LEN > 32) begin : g_bad_params
    $error("lcd_msg_sequencer: illegal CLK_FREQ or MSG_LEN");
  end

  typedef enum logic [3:0] {
    IDLE, INIT_WAIT, CLR_ISSUE, CLR_HOLD, GAP,
    FETCH, UART_WAIT, WR_ISSUE, WR_HOLD, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lcd_ready_q, lcd_ready_d;
  logic            auto_q, auto_d;
  logic [5:0]      char_idx_q, char_idx_d;
  logic [7:0]      cur_q, cur_d;
  logic            strobe_q, strobe_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            uart_start_q, uart_start_d;
  logic [7:0]      uart_data_q, uart_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [7:0]      fetch_byte;
  logic            is_newline;
  logic [CW-1:0]   gap_delay;

  // Select msg byte char_idx; indices at or past MSG_LEN read as 0x00.
  always_comb begin
    fetch_byte = 8'h00;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (char_idx_q == 6'(k)) fetch_byte = msg[8*k +: 8];
    end
  end

  assign is_newline = (cur_q == 8'h0A);

  // Idle time after a write: command writes (clear, newline) wait longer.
  always_comb begin
    if (state_q == CLR_ISSUE || state_q == CLR_HOLD || is_newline) gap_delay = CW'(CMD_DELAY);
    else                                                          gap_delay = CW'(CHAR_DELAY);
  end

  // Next-state logic, plus next values of the registered outputs.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    lcd_ready_d  = lcd_ready_q;
    auto_d       = auto_q;
    char_idx_d   = char_idx_q;
    cur_d        = cur_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    uart_data_d  = uart_data_q;
    uart_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          auto_d     = 1'b0;
          char_idx_d = '0;
          if (lcd_ready_q) begin
            state_d = CLR_ISSUE;
          end else begin
            state_d = INIT_WAIT;
            cnt_d   = CW'(INIT_DELAY);
          end
        end
      end
      INIT_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          lcd_ready_d = 1'b1;
          state_d     = CLR_ISSUE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CLR_ISSUE, WR_ISSUE: begin
        if (HOLD_CYCLES == 0) begin
          state_d = GAP;
          cnt_d   = gap_delay;
          if (state_q == WR_ISSUE) char_idx_d = char_idx_q + 6'd1;
        end else begin
          state_d = (state_q == CLR_ISSUE) ? CLR_HOLD : WR_HOLD;
          cnt_d   = CW'(HOLD_CYCLES);
        end
      end
      CLR_HOLD, WR_HOLD: begin
        if (cnt_q <= CW'(1)) begin
          state_d = GAP;
          cnt_d   = gap_delay;
          if (state_q == WR_HOLD) char_idx_d = char_idx_q + 6'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q <= CW'(1)) state_d = FETCH;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      FETCH: begin
        if (char_idx_q == END_IDX || fetch_byte == 8'h00) begin
          state_d = DONE;
        end else begin
          cur_d   = fetch_byte;
          state_d = UART_WAIT;
        end
      end
      UART_WAIT: begin
        if (!uart_busy) begin
          uart_start_d = 1'b1;
          uart_data_d  = cur_q;
          state_d      = WR_ISSUE;
        end
      end
      DONE: begin
        if (start) begin
          char_idx_d = '0;
          state_d    = CLR_ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered, so they line up with it once
    // registered and stay constant across every hold cycle.
    strobe_d = (state_d == CLR_ISSUE) || (state_d == CLR_HOLD) ||
               (state_d == WR_ISSUE)  || (state_d == WR_HOLD);
    if (state_d == CLR_ISSUE) begin
      addr_d  = REG_CMD;
      wdata_d = CMD_CLR;
    end else if (state_d == WR_ISSUE && state_q != WR_ISSUE) begin
      addr_d  = is_newline ? REG_CMD   : REG_DATA;
      wdata_d = is_newline ? CMD_LINE2 : cur_q;
    end
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // State, counters and registered outputs; rst clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lcd_ready_q  <= 1'b0;
      auto_q       <= (AUTO_START != 0);
      char_idx_q   <= '0;
      cur_q        <= '0;
      strobe_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      uart_start_q <= 1'b0;
      uart_data_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values computed above, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lcd_ready_q  <= lcd_ready_d;
      auto_q       <= auto_d;
      char_idx_q   <= char_idx_d;
      cur_q        <= cur_d;
      strobe_q     <= strobe_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      uart_start_q <= uart_start_d;
      uart_data_q  <= uart_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lcd_cs     = strobe_q;
  assign lcd_we     = strobe_q;
  assign lcd_addr   = addr_q;
  assign lcd_wdata  = wdata_q;
  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign char_idx   = char_idx_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed bench for lcd_msg_sequencer with INIT_DELAY=20, HOLD_CYCLES=3,
// CMD_DELAY=10, CHAR_DELAY=5, MSG_LEN=3. Outputs are sampled 1 ns after
// each rising edge.
//
// Hand-derived timing (edges counted from the sample where cs was last low):
//   after a command write (clear or 0x0A): 10 gap + FETCH + UART_WAIT = 12
//   after a data write:                     5 gap + FETCH + UART_WAIT = 7
//   each write holds cs/we for 1 + 3 = 4 cycles
//   last data write to done: 5 gap + FETCH = 6
`timescale 1ns/1ps

module tb_lcd_msg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] msg;
  logic        lcd_cs, lcd_we;
  logic [7:0]  lcd_addr, lcd_wdata;
  logic        uart_start;
  logic [7:0]  uart_data;
  logic        uart_busy;
  logic        busy, done;
  logic [5:0]  char_idx;

  int errors = 0;
  int checks = 0;

  logic [7:0] uart_log [32];
  int         uart_n = 0;

  localparam logic [23:0] MSG_HNW = 24'h570A48;  // "H", "\n", "W"
  localparam logic [23:0] MSG_A0B = 24'h420041;  // 'A', 0x00, 'B'

  lcd_msg_sequencer #(
    .CLK_FREQ(25000000), .MSG_LEN(3), .INIT_DELAY(20), .CMD_DELAY(10),
    .CHAR_DELAY(5), .HOLD_CYCLES(3), .AUTO_START(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg),
    .lcd_cs(lcd_cs), .lcd_we(lcd_we), .lcd_addr(lcd_addr), .lcd_wdata(lcd_wdata),
    .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy),
    .busy(busy), .done(done), .char_idx(char_idx)
  );

  always #5 clk = ~clk;

  // Log every byte handed to the UART.
  always @(negedge clk) begin
    if (uart_start === 1'b1) begin
      if (uart_n < 32) uart_log[uart_n] = uart_data;
      uart_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until lcd_cs goes high (bounded).
  task automatic wait_cs_high(input int max, output int n);
    n = 0;
    while (lcd_cs !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  // Expect a write after 'gap' low cycles, 4 cycles long, stable addr/data.
  task automatic expect_write(input string tag, input int gap,
                              input logic [7:0] a, input logic [7:0] d);
    int n;
    logic stable;
    wait_cs_high(300, n);
    check({tag, "_gap"}, n, gap);
    check({tag, "_we"}, lcd_we, 1'b1);
    check({tag, "_addr"}, lcd_addr, a);
    check({tag, "_wdata"}, lcd_wdata, d);
    n = 1;
    stable = 1'b1;
    while (lcd_cs === 1'b1 && n < 50) begin
      tick();
      if (lcd_cs === 1'b1) begin
        n++;
        if (lcd_addr !== a || lcd_wdata !== d || lcd_we !== 1'b1) stable = 1'b0;
      end
    end
    check({tag, "_len"}, n, 4);
    check({tag, "_stable"}, stable, 1'b1);
  endtask

  // Count edges until done rises; report whether cs pulsed meanwhile.
  task automatic wait_done(input int max, output int n, output logic cs_seen);
    n = 0;
    cs_seen = 1'b0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
      if (lcd_cs === 1'b1) cs_seen = 1'b1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int uc;
    logic cs_seen;

    rst = 1'b1; start = 1'b0; uart_busy = 1'b0; msg = MSG_HNW;

    // Reset state
    repeat (2) tick();
    check("rst_cs", lcd_cs, 1'b0);
    check("rst_we", lcd_we, 1'b0);
    check("rst_addr", lcd_addr, 8'h00);
    check("rst_wdata", lcd_wdata, 8'h00);
    check("rst_uart", {uart_start, uart_data}, 9'h000);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_idx", char_idx, 6'd0);

    // Replay 1: auto start, init wait, clear, "H\nW"
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("r1_busy", busy, 1'b1);
    check("r1_cs_idle", lcd_cs, 1'b0);
    expect_write("r1_clr", 20, 8'h01, 8'h01);
    expect_write("r1_h",   12, 8'h00, 8'h48);
    expect_write("r1_nl",   7, 8'h01, 8'hC0);
    expect_write("r1_w",   12, 8'h00, 8'h57);
    wait_done(100, n, cs_seen);
    check("r1_done_lat", n, 6);
    check("r1_done_cs", cs_seen, 1'b0);
    check("r1_busy_end", busy, 1'b0);
    check("r1_idx", char_idx, 6'd3);
    check("r1_uart_n", uart_n, 3);
    check("r1_uart0", uart_log[0], 8'h48);
    check("r1_uart1", uart_log[1], 8'h0A);
    check("r1_uart2", uart_log[2], 8'h57);

    // Replay 2: restart from DONE skips init; ignored start; UART stall
    repeat (3) tick();
    pulse_start();
    check("r2_cs_now", lcd_cs, 1'b1);
    check("r2_idx0", char_idx, 6'd0);
    check("r2_done_low", done, 1'b0);
    expect_write("r2_clr", 0, 8'h01, 8'h01);
    // start while busy: one gap cycle is used by the pulse, so 12 - 1
    pulse_start();
    check("r2_busy_start", {busy, done}, 2'b10);
    expect_write("r2_h", 11, 8'h00, 8'h48);
    uart_busy = 1'b1;
    uc = uart_n;
    cs_seen = 1'b0;
    repeat (50) begin
      tick();
      if (lcd_cs === 1'b1) cs_seen = 1'b1;
    end
    check("r2_stall_cs", cs_seen, 1'b0);
    check("r2_stall_uart", uart_n, uc);
    uart_busy = 1'b0;
    tick();
    check("r2_cs_after_busy", lcd_cs, 1'b1);
    expect_write("r2_nl", 0, 8'h01, 8'hC0);
    check("r2_one_pulse", uart_n, uc + 1);
    expect_write("r2_w", 12, 8'h00, 8'h57);
    wait_done(100, n, cs_seen);
    check("r2_done_lat", n, 6);
    check("r2_uart_n", uart_n, 6);
    check("r2_uart5", uart_log[5], 8'h57);

    // Replay 3: 0x00 terminator after 'A'
    msg = MSG_A0B;
    repeat (2) tick();
    pulse_start();
    expect_write("r3_clr", 0, 8'h01, 8'h01);
    expect_write("r3_a",  12, 8'h00, 8'h41);
    wait_done(100, n, cs_seen);
    check("r3_done_lat", n, 6);
    check("r3_no_more_cs", cs_seen, 1'b0);
    check("r3_idx", char_idx, 6'd1);
    check("r3_uart_n", uart_n, 7);
    check("r3_uart6", uart_log[6], 8'h41);

    // Replay 4: reset during WR_HOLD, then full replay with init wait
    msg = MSG_HNW;
    repeat (2) tick();
    pulse_start();
    expect_write("r4_clr", 0, 8'h01, 8'h01);
    wait_cs_high(300, n);
    check("r4_h_gap", n, 12);
    tick();                       // now in WR_HOLD
    #2 rst = 1'b1;
    #1;
    check("r4_rst_cs_we", {lcd_cs, lcd_we}, 2'b00);
    check("r4_rst_addr_data", {lcd_addr, lcd_wdata}, 16'h0000);
    check("r4_rst_busy_done", {busy, done}, 2'b00);
    check("r4_rst_idx", char_idx, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("r4_busy", busy, 1'b1);
    expect_write("r4_clr2", 20, 8'h01, 8'h01);
    expect_write("r4_h2",   12, 8'h00, 8'h48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
